// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW + 1)'(1);
                2'b01:   count_d = count_q - (PW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, prefetch FIFO, redirect/flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = FETCH_XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stall_cycles
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;

    logic            req_fire;
    logic            rsp_fire;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_in;
    logic [CW-1:0]   fifo_count;

    // A slot is reserved at issue: no new request while one is in flight,
    // so only the FIFO occupancy gates issue.
    assign imem_req_valid = reset && !outstanding_q && !redirect_valid
                            && (fifo_count < FULL_COUNT);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && outstanding_q;
    assign fifo_push      = rsp_fire && !drop_q && !redirect_valid;
    assign fifo_pop       = inst_valid && inst_ready;
    assign fifo_in        = '{pc: req_pc_q, inst: imem_rsp_data};

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = inst_valid ? fifo_head.inst : '0;
    assign inst_pc    = inst_valid ? fifo_head.pc : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // A response landing in the redirect cycle is consumed here, so
            // only a still-pending request needs the drop flag.
            fetch_pc_d    = redirect_pc & ~XLEN'(3);
            outstanding_d = outstanding_q && !imem_rsp_valid;
            drop_d        = outstanding_q && !imem_rsp_valid;
        end else if (req_fire) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            req_pc_d      = fetch_pc_q;
            outstanding_d = 1'b1;
        end else if (rsp_fire) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_entry(fifo_in),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_redirects_d = perf_redirects_q + 32'(redirect_valid);
        perf_stall_d     = perf_stall_q + 32'(inst_ready && !inst_valid);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_redirects_q <= '0;
            perf_stall_q     <= '0;
        end else begin
            perf_redirects_q <= perf_redirects_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_redirects    = perf_redirects_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_redirects    = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;

    int tests = 0;
    int fails = 0;

    // Memory model state
    int          rsp_delay = 0;
    logic        pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = '0;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_REDIRECTS = 32'd2;
    localparam logic [31:0] EXP_STALLS    = 32'd5;
`else
    localparam logic [31:0] EXP_REDIRECTS = 32'd0;
    localparam logic [31:0] EXP_STALLS    = 32'd0;
`endif

    fetch_unit #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .perf_redirects   (perf_redirects),
        .perf_stall_cycles(perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "simulation time limit exceeded");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake mid-cycle, then advance the memory model.
    task automatic tick();
        logic        f;
        logic [31:0] a;
        @(negedge clk);
        f = imem_req_valid && imem_req_ready;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (f) begin
            if (rsp_delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(a);
            end else begin
                pend      = 1'b1;
                pend_cnt  = rsp_delay - 1;
                pend_addr = a;
            end
        end
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        tick();
        tick();

        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_perf_red", perf_redirects, 32'h0);
        chk("rst_perf_stall", perf_stall_cycles, 32'h0);

        // Release reset: request at RESET_PC in the first cycle.
        reset = 1'b1;
        #1;
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_req_valid", 32'(imem_req_valid), 32'd0);
        chk("c1_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst_pc", inst_pc, 32'h0);
        chk("c2_inst_data", inst_data, 32'h0000_0013);
        chk("c2_addr", imem_addr, 32'h4);
        tick();
        tick();
        chk("c4_addr", imem_addr, 32'h8);
        tick();
        tick();
        chk("c6_addr", imem_addr, 32'hC);
        tick();
        tick();

        // FIFO full with decode stalled: issue stops.
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("full_addr", imem_addr, 32'h10);
        tick();
        tick();
        tick();
        chk("full_hold_req", 32'(imem_req_valid), 32'd0);
        chk("full_head_pc", inst_pc, 32'h0);

        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("pop_req_valid", 32'(imem_req_valid), 32'd1);
        chk("pop_addr", imem_addr, 32'h10);
        chk("pop_head_pc", inst_pc, 32'h4);
        chk("pop_head_data", inst_data, 32'h0000_0413);

        // Memory not ready for 3 cycles: request held stable.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_addr, 32'h10);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("hs_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("hs_full_req", 32'(imem_req_valid), 32'd0);

        // Drain with memory frozen; exactly one entry for 0x10.
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        #1;
        chk("drain_pc0", inst_pc, 32'h4);
        tick();
        chk("drain_pc1", inst_pc, 32'h8);
        tick();
        chk("drain_pc2", inst_pc, 32'hC);
        tick();
        chk("drain_pc3", inst_pc, 32'h10);
        chk("drain_data3", inst_data, 32'h0000_1013);
        tick();
        inst_ready = 1'b0;
        #1;
        chk("drain_empty", 32'(inst_valid), 32'd0);
        chk("drain_addr", imem_addr, 32'h14);

        // Redirect while a slow response is outstanding.
        rsp_delay      = 2;
        imem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir_req_low", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_wait_req", 32'(imem_req_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        chk("redir_rsp_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("redir_drop_empty", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_addr, 32'h100);
        rsp_delay = 0;
        tick();
        tick();
        chk("redir_inst_valid", 32'(inst_valid), 32'd1);
        chk("redir_inst_pc", inst_pc, 32'h100);
        chk("redir_inst_data", inst_data, 32'h0001_0013);
        chk("redir_next_addr", imem_addr, 32'h104);

        // Redirect with same-cycle pop to the top word; address wraps.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        inst_ready     = 1'b1;
        #1;
        chk("wrap_req_low", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("wrap_flushed", 32'(inst_valid), 32'd0);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_outst", 32'(imem_req_valid), 32'd0);
        tick();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst_data", inst_data, 32'hFFFF_FC13);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("perf_redirects", perf_redirects, EXP_REDIRECTS);

        // Starve decode for exactly 5 cycles.
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        inst_ready = 1'b0;
        #1;
        chk("perf_stalls", perf_stall_cycles, EXP_STALLS);

        // Response with nothing outstanding is ignored.
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        chk("spurious_rsp", 32'(inst_valid), 32'd0);
        chk("spurious_addr", imem_addr, 32'h0);

        // Response arriving in the redirect cycle: discarded, no drop pending.
        imem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("samecyc_req_valid", 32'(imem_req_valid), 32'd1);
        chk("samecyc_addr", imem_addr, 32'h200);
        chk("samecyc_empty", 32'(inst_valid), 32'd0);

        // Reset mid-stream clears everything.
        reset = 1'b0;
        tick();
        chk("mid_rst_req", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_inst", 32'(inst_valid), 32'd0);
        chk("mid_rst_perf_red", perf_redirects, 32'h0);
        chk("mid_rst_perf_stall", perf_stall_cycles, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
